// File: rtl/k423_if_fetch_q_if.sv
// Fetch-queue bus bundle: memory request/response channel and decode-side handshake.
// master is the fetch queue, slave is the memory/decode environment.
interface k423_if_fetch_q_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              mem_req_vld_o;
  logic              mem_req_rdy_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_rsp_vld_i;
  logic [INST_W-1:0] mem_rsp_rdata_i;
  logic              inst_vld_o;
  logic              inst_rdy_i;
  logic [ADDR_W-1:0] inst_pc_o;
  logic [INST_W-1:0] inst_o;

  modport master (
    output mem_req_vld_o, mem_req_addr_o, inst_vld_o, inst_pc_o, inst_o,
    input  mem_req_rdy_i, mem_rsp_vld_i, mem_rsp_rdata_i, inst_rdy_i
  );

  modport slave (
    input  mem_req_vld_o, mem_req_addr_o, inst_vld_o, inst_pc_o, inst_o,
    output mem_req_rdy_i, mem_rsp_vld_i, mem_rsp_rdata_i, inst_rdy_i
  );
endinterface

// File: rtl/k423_if_fetch_q.sv
// Instruction fetch queue: credit-limited request issue, in-order response capture,
// redirect handling that drops responses still in flight when a flush arrives.
module k423_if_fetch_q #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OS   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              stall_i,
  k423_if_fetch_q_if.master bus
);

  localparam int unsigned       PtrW   = $clog2(DEPTH);
  localparam int unsigned       CntW   = $clog2(DEPTH + 1);
  localparam logic [CntW:0]     DepthL = (CntW + 1)'(DEPTH);
  localparam logic [CntW-1:0]   MaxOsL = CntW'(MAX_OS);
  localparam logic [ADDR_W-1:0] PcInc  = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   os_cnt_q, os_cnt_d;
  logic [CntW-1:0]   q_cnt_q, q_cnt_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [CntW:0] credit_use;
  logic          req_vld;
  logic          req_acc;
  logic          rsp_vld;
  logic          dropping;
  logic          rsp_keep;
  logic          pop;

  // Counting queued plus in-flight entries guarantees every response has a free slot.
  assign credit_use = {1'b0, os_cnt_q} + {1'b0, q_cnt_q};
  assign req_vld    = rst_n_i & ~flush_i & ~stall_i & (os_cnt_q < MaxOsL) &
                      (credit_use < DepthL);
  assign req_acc    = req_vld & bus.mem_req_rdy_i;
  assign rsp_vld    = bus.mem_rsp_vld_i;
  assign dropping   = (drop_cnt_q != '0);
  assign rsp_keep   = rsp_vld & ~dropping & ~flush_i;
  assign pop        = (q_cnt_q != '0) & bus.inst_rdy_i & ~flush_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    q_cnt_d    = q_cnt_q;
    drop_cnt_d = drop_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    // Outstanding count tracks the bus, so it keeps counting across a flush.
    os_cnt_d   = os_cnt_q + CntW'(req_acc) - CntW'(rsp_vld);

    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
      rsp_pc_d   = flush_pc_i;
      q_cnt_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = os_cnt_q - CntW'(rsp_vld);
    end else begin
      if (req_acc) fetch_pc_d = fetch_pc_q + PcInc;
      if (rsp_vld && dropping) drop_cnt_d = drop_cnt_q - CntW'(1);
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + PcInc;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      q_cnt_d = q_cnt_q + CntW'(rsp_keep) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      os_cnt_q   <= '0;
      q_cnt_q    <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      os_cnt_q   <= os_cnt_d;
      q_cnt_q    <= q_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_keep) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      inst_mem[wr_ptr_q] <= bus.mem_rsp_rdata_i;
    end
  end

  assign bus.mem_req_vld_o  = req_vld;
  assign bus.mem_req_addr_o = fetch_pc_q;
  assign bus.inst_vld_o     = (q_cnt_q != '0);
  assign bus.inst_pc_o      = pc_mem[rd_ptr_q];
  assign bus.inst_o         = inst_mem[rd_ptr_q];

endmodule

// File: tb/tb_k423_if_fetch_q.sv
// Bench for k423_if_fetch_q: memory/decode environment plus an epoch-tagged queue model
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_k423_if_fetch_q;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAX_OS = 2;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } os_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall;

  k423_if_fetch_q_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  k423_if_fetch_q #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .DEPTH   (DEPTH),
    .MAX_OS  (MAX_OS),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .flush_i   (flush),
    .flush_pc_i(flush_pc),
    .stall_i   (stall),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  os_t         os_q[$];
  ent_t        mq[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_inst[$];
  logic [31:0] exp_pc;
  int          epoch, cyc, lat_lo, lat_hi;
  int          errors, checks;
  int          n_pop, n_drop, n_acc;
  logic        last_req_vld, last_inst_vld;
  logic [31:0] last_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] get_pc(input int i);
    return (i < popped_pc.size()) ? popped_pc[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] get_inst(input int i);
    return (i < popped_inst.size()) ? popped_inst[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_contig(input string nm);
    int bad = 0;
    for (int i = 1; i < popped_pc.size(); i++)
      if (popped_pc[i] !== popped_pc[i-1] + 32'd4) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(input logic fl, input logic [31:0] fpc, input logic st,
                      input logic rrdy, input logic irdy);
    logic rsp, acc, pop, exp_vld;
    os_t  e;
    int   d;
    @(negedge clk);
    flush = fl; flush_pc = fpc; stall = st;
    bus.mem_req_rdy_i = rrdy;
    bus.inst_rdy_i    = irdy;
    rsp = (os_q.size() > 0) && (os_q[0].due <= cyc);
    bus.mem_rsp_vld_i   = rsp;
    bus.mem_rsp_rdata_i = rsp ? data_of(os_q[0].addr) : 32'h0;
    #1;
    exp_vld = !fl && !st && (os_q.size() < MAX_OS) && (os_q.size() + mq.size() < DEPTH);
    chk("req_vld", 32'(bus.mem_req_vld_o), 32'(exp_vld));
    chk("req_addr", bus.mem_req_addr_o, exp_pc);
    chk("inst_vld", 32'(bus.inst_vld_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("inst_pc", bus.inst_pc_o, mq[0].pc);
      chk("inst", bus.inst_o, mq[0].inst);
    end
    checks++;
    if (os_q.size() > MAX_OS || mq.size() > DEPTH) begin
      errors++;
      $display("FAIL bounds: os=%0d q=%0d limits %0d/%0d", os_q.size(), mq.size(), MAX_OS, DEPTH);
    end
    last_req_vld  = bus.mem_req_vld_o;
    last_inst_vld = bus.inst_vld_o;
    last_addr     = bus.mem_req_addr_o;
    acc = bus.mem_req_vld_o && rrdy;
    pop = bus.inst_vld_o && irdy && !fl;
    if (acc) n_acc++;
    if (pop) begin
      popped_pc.push_back(bus.inst_pc_o);
      popped_inst.push_back(bus.inst_o);
      n_pop++;
      if (mq.size() > 0) void'(mq.pop_front());
    end
    if (rsp) begin
      e = os_q.pop_front();
      if (!fl && e.epoch == epoch) mq.push_back('{e.addr, data_of(e.addr)});
      else if (!fl) n_drop++;
    end
    if (fl) begin
      mq.delete();
      popped_pc.delete();
      popped_inst.delete();
      epoch++;
      exp_pc = fpc;
    end else if (acc) begin
      exp_pc = exp_pc + 32'd4;
    end
    if (acc) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (os_q.size() > 0 && os_q[$].due >= d) d = os_q[$].due + 1;
      os_q.push_back('{bus.mem_req_addr_o, epoch, d});
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    bus.mem_req_rdy_i = 1'b0; bus.inst_rdy_i = 1'b0; bus.mem_rsp_vld_i = 1'b0;
    #1;
    chk("rst_req_vld", 32'(bus.mem_req_vld_o), 32'd0);
    chk("rst_inst_vld", 32'(bus.inst_vld_o), 32'd0);
    repeat (2) @(negedge clk);
    os_q.delete(); mq.delete(); popped_pc.delete(); popped_inst.delete();
    exp_pc = 32'h8000_0000; epoch = 0; cyc = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; stall = 1'b0;
    bus.mem_req_rdy_i = 1'b0; bus.inst_rdy_i = 1'b0;
    bus.mem_rsp_vld_i = 1'b0; bus.mem_rsp_rdata_i = '0;
    errors = 0; checks = 0; lat_lo = 1; lat_hi = 1;
    n_pop = 0; n_drop = 0; n_acc = 0; epoch = 0; cyc = 0; exp_pc = 32'h8000_0000;

    // Streaming: one instruction per cycle from cycle 2 onward.
    do_reset();
    n_pop = 0;
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("stream_pc0", get_pc(0), 32'h8000_0000);
    chk("stream_pc1", get_pc(1), 32'h8000_0004);
    chk("stream_pc2", get_pc(2), 32'h8000_0008);
    chk("stream_pops", 32'(n_pop), 32'd10);
    check_contig("stream_contig");

    // Decode backpressure: queue fills to DEPTH, requests stop, then drains in order.
    n_acc = 0;
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_accepts", 32'(n_acc), 32'd2);
    chk("bp_kept", 32'(mq.size()), 32'd4);
    chk("bp_req_vld", 32'(last_req_vld), 32'd0);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check_contig("drain_contig");

    // Flush with two requests outstanding and no response in the flush cycle.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    lat_lo = 1; lat_hi = 1; n_drop = 0;
    step(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("fl2_drops", 32'(n_drop), 32'd2);
    chk("fl2_first_pc", get_pc(0), 32'h0000_0100);
    chk("fl2_first_inst", get_inst(0), 32'h1257_6420);

    // Flush coinciding with a response, two outstanding: only one later drop.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    lat_lo = 1; lat_hi = 1; n_drop = 0;
    step(1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("flr_drops", 32'(n_drop), 32'd1);
    chk("flr_first_pc", get_pc(0), 32'h0000_0300);

    // Stall: no requests for 5 cycles, queue drains, fetch PC held.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("rst_first_addr", last_addr, 32'h8000_0000);
    chk("rst_first_vld", 32'(last_req_vld), 32'd1);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    n_pop = 0; n_acc = 0;
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("stall_accepts", 32'(n_acc), 32'd0);
    chk("stall_pops", 32'(n_pop), 32'd2);
    chk("stall_addr", last_addr, 32'h8000_0010);
    chk("stall_inst_vld", 32'(last_inst_vld), 32'd0);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check_contig("stall_contig");

    // Redirect near the top of the address space: PC wraps to zero.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("wrap_first_addr", last_addr, 32'hFFFF_FFF8);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("wrap_pc1", get_pc(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", get_pc(2), 32'h0000_0000);

    // Random ready, latency, stalls and occasional redirects.
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39, 0) == 0), $urandom() & 32'hFFFF_FFFC,
           ($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    check_contig("rand_contig");

    // Reset in the middle of random traffic abandons everything in flight.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("midrst_addr", last_addr, 32'h8000_0000);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("midrst_pc0", get_pc(0), 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
